// File: rtl/aes_ct_unpacker_if.sv
// ----------------------------------------------------------------------------
// aes_ct_unpacker_if
// Purpose : Bundles the cipher-block input and the 32-bit word stream output
//           of the AES ciphertext unpacker into one connection.
// Modports:
//   master - the environment: drives valid_in / cipher_text / word_ready /
//            clr_overflow and observes the word stream and status.
//   slave  - the unpacker itself: the opposite directions.
// Signals :
//   valid_in     one cipher block offered this cycle (encryptor valid_out)
//   cipher_text  DATA_W-bit block captured when valid_in = 1
//   word_out     current output word, 0 when word_valid = 0
//   word_valid   word_out holds a valid word
//   word_ready   consumer accepts word_out this cycle
//   word_last    high with the final word of a block
//   level        blocks held, including a partially sent head block
//   overflow     sticky flag: at least one block was dropped
//   clr_overflow synchronous clear of overflow
// ----------------------------------------------------------------------------
interface aes_ct_unpacker_if #(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              valid_in;
    logic [DATA_W-1:0] cipher_text;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic              word_last;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              clr_overflow;

    modport master (
        output valid_in,
        output cipher_text,
        output word_ready,
        output clr_overflow,
        input  word_out,
        input  word_valid,
        input  word_last,
        input  level,
        input  overflow
    );

    modport slave (
        input  valid_in,
        input  cipher_text,
        input  word_ready,
        input  clr_overflow,
        output word_out,
        output word_valid,
        output word_last,
        output level,
        output overflow
    );
endinterface

// File: rtl/aes_ct_unpacker.sv
// ----------------------------------------------------------------------------
// aes_ct_unpacker
// Purpose : Output stage behind the pipelined AES-128 encryptor. Every block
//           flagged by valid_in is written into a DEPTH-entry block FIFO and
//           then streamed out most-significant word first as WORD_W-bit words
//           over a valid/ready handshake. The encryptor cannot stall, so a
//           block arriving while the FIFO is full is dropped and recorded in a
//           sticky overflow flag; upstream is never back-pressured.
// Ports   :
//   clk    - single clock, all state changes on its rising edge
//   reset  - asynchronous, active-high; clears pointers, word index, level
//            and overflow (array contents are left as they are)
//   bus    - aes_ct_unpacker_if.slave: block input, word stream, status
// ----------------------------------------------------------------------------
module aes_ct_unpacker #(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    aes_ct_unpacker_if.slave    bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int WORDS = DATA_W / WORD_W;

    // Block storage and bookkeeping
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;
    logic [1:0]        r_widx;
    logic              r_overflow;

    logic              w_valid;
    logic              w_handshake;
    logic              w_last;
    logic              w_release;
    logic              w_full;
    logic              w_write;
    logic              w_drop;
    logic [DATA_W-1:0] w_head;
    logic [WORD_W-1:0] w_word;

    assign w_valid     = (r_level != '0);
    assign w_last      = w_valid && (r_widx == 2'(WORDS - 1));
    assign w_handshake = w_valid && bus.word_ready;
    assign w_release   = w_handshake && (r_widx == 2'(WORDS - 1));

    // A release in the same cycle frees the head slot, so a full FIFO can
    // still take the incoming block: the write lands in the slot being freed
    // once the pointers wrap, and level stays at DEPTH.
    assign w_full  = (r_level == LW'(DEPTH)) && !w_release;
    assign w_write = bus.valid_in && !w_full;
    assign w_drop  = bus.valid_in && w_full;

    assign w_head  = r_mem[r_rptr];

    // Word 0 is the most-significant slice of the block.
    always_comb begin
        w_word = '0;
        if (w_valid) begin
            w_word = w_head[(DATA_W - 1 - WORD_W * int'(r_widx)) -: WORD_W];
        end
    end

    // Storage array: no reset, contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wptr] <= bus.cipher_text;
        end
    end

    // Write pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
        end else if (w_write) begin
            r_wptr <= r_wptr + 1'b1;
        end
    end

    // Read pointer and word index into the head block
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rptr <= '0;
            r_widx <= '0;
        end else if (w_handshake) begin
            r_widx <= r_widx + 2'd1;
            if (w_release) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Block count: simultaneous write and release cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
        end else if (w_write && !w_release) begin
            r_level <= r_level + 1'b1;
        end else if (!w_write && w_release) begin
            r_level <= r_level - 1'b1;
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.word_out   = w_word;
    assign bus.word_valid = w_valid;
    assign bus.word_last  = w_last;
    assign bus.level      = r_level;
    assign bus.overflow   = r_overflow;

endmodule
